// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch front end. It owns the program counter and drives it out
//   as the instruction-memory address. Each cycle it can capture the returned
//   instruction and its PC into a DEPTH-entry FIFO. The consumer drains the
//   head through a valid/ready handshake. A branch flushes the FIFO and
//   reloads the PC.
//
// Ports
//   clk, reset       rising-edge clock; synchronous active-high reset
//   pc               fetch address for this cycle
//   instruction      memory read data for pc (same-cycle, combinational)
//   branch_en        redirect request: flush the queue, load branch_target
//   branch_target    new PC when branch_en is set
//   instr_out        head instruction (0 while the queue is empty)
//   instr_pc         head PC (0 while the queue is empty)
//   instr_pc8        instr_pc + 8, the PC-relative operand value
//   instr_valid      head entry present
//   instr_ready      consumer takes the head this cycle
//   count            occupied entries, 0..DEPTH
module fetch_queue_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      PC_STEP  = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [WIDTH-1:0]         pc,
    input  logic [WIDTH-1:0]         instruction,
    input  logic                     branch_en,
    input  logic [WIDTH-1:0]         branch_target,
    output logic [WIDTH-1:0]         instr_out,
    output logic [WIDTH-1:0]         instr_pc,
    output logic [WIDTH-1:0]         instr_pc8,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [WIDTH-1:0] mem_pc    [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push;
    logic             pop;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    // A pop frees a slot in the same cycle, so a full queue keeps streaming.
    assign push        = !branch_en & ((count < CW'(DEPTH)) | pop);

    // No bypass: a freshly fetched entry only appears at the head next cycle.
    // The head is zeroed while empty so stale storage never leaks out.
    assign instr_out = instr_valid ? mem_instr[rd_ptr] : '0;
    assign instr_pc  = instr_valid ? mem_pc[rd_ptr]    : '0;
    assign instr_pc8 = instr_pc + WIDTH'(8);

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_instr[wr_ptr] <= instruction;
            mem_pc[wr_ptr]    <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (branch_en) begin
            // Flush wins over any pop requested in the same cycle.
            pc     <= branch_target;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                pc     <= pc + WIDTH'(PC_STEP);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit. A queue-based reference model tracks the
// expected FIFO contents and PC. A second instance with a wrapping reset PC
// covers address wrap-around.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset, branch_en, instr_ready;
    logic [31:0] instruction, branch_target;
    logic [31:0] pc, instr_out, instr_pc, instr_pc8;
    logic        instr_valid;
    logic [2:0]  count;

    logic        reset2, ready2;
    logic [31:0] pc2, out2, ipc2, ipc8_2;
    logic        valid2;
    logic [2:0]  count2;

    always #5 clk = ~clk;

    fetch_queue_unit #(.WIDTH(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
        .branch_en(branch_en), .branch_target(branch_target),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_pc8(instr_pc8),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .count(count));

    // Memory model for the wrap instance: each word holds its own address.
    fetch_queue_unit #(.WIDTH(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset2), .pc(pc2), .instruction(pc2),
        .branch_en(1'b0), .branch_target(32'h0),
        .instr_out(out2), .instr_pc(ipc2), .instr_pc8(ipc8_2),
        .instr_valid(valid2), .instr_ready(ready2), .count(count2));

    typedef struct { logic [31:0] ins; logic [31:0] pc; } entry_t;
    entry_t      mq[$];
    logic [31:0] mpc;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check registered state, apply one cycle of inputs, advance the model.
    task automatic cyc(input logic rst, input logic br, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] ins);
        bit do_pop, do_push;
        entry_t e;
        reset = rst; branch_en = br; branch_target = tgt;
        instr_ready = rdy; instruction = ins;
        #1;
        chk("pc", pc, mpc);
        chk("count", 32'(count), 32'(mq.size()));
        chk("valid", 32'(instr_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("instr_out", instr_out, mq[0].ins);
            chk("instr_pc", instr_pc, mq[0].pc);
            chk("instr_pc8", instr_pc8, mq[0].pc + 32'd8);
        end else begin
            chk("instr_out_empty", instr_out, 32'h0);
            chk("instr_pc_empty", instr_pc, 32'h0);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete(); mpc = 32'h0;
        end else if (br) begin
            mq.delete(); mpc = tgt;
        end else begin
            do_pop  = (mq.size() != 0) && rdy;
            do_push = (mq.size() < 4) || do_pop;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.ins = ins; e.pc = mpc;
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; branch_en = 1'b0; branch_target = 32'h0;
        instr_ready = 1'b0; instruction = 32'hE594_4010;
        reset2 = 1'b1; ready2 = 1'b0;
        @(posedge clk); @(negedge clk);
        mq.delete(); mpc = 32'h0;

        // Reset held for a second cycle, then checked.
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'hE594_4010);
        // Fill to full, then stall.
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'hE084_1009);
        // Stream while full.
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hE084_1009 + 32'(i));
        // Branch flush while full and draining.
        cyc(1'b0, 1'b1, 32'h40, 1'b1, 32'h1111_1111);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h2222_0000 + 32'(i));
        // Mid-stream reset with three entries queued.
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h3333_0000 + 32'(i));
        cyc(1'b1, 1'b1, 32'h80, 1'b1, 32'h0);
        // Pointer wrap ordering: instruction mirrors the fetch address.
        for (int i = 0; i < 25; i++) begin
            logic [4:0] pat;
            pat = 5'b01101;
            cyc(1'b0, 1'b0, 32'h0, pat[i % 5], mpc);
        end
        // Drain fully, then empty-with-ready.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h100, 1'b1, mpc);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                {$urandom_range(0, 32'h3FFF), 2'b00}, 1'($urandom), $urandom);
        end

        // PC wrap on the second instance.
        @(negedge clk);
        reset2 = 1'b0; ready2 = 1'b1;
        #1;
        chk("w_pc0", pc2, 32'hFFFF_FFF8);
        chk("w_valid0", 32'(valid2), 32'h0);
        @(posedge clk); #1;
        chk("w_pc1", pc2, 32'hFFFF_FFFC);
        chk("w_ipc1", ipc2, 32'hFFFF_FFF8);
        chk("w_pc8_1", ipc8_2, 32'h0);
        chk("w_out1", out2, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        chk("w_pc2", pc2, 32'h0);
        chk("w_ipc2", ipc2, 32'hFFFF_FFFC);
        chk("w_pc8_2", ipc8_2, 32'h4);
        @(posedge clk); #1;
        chk("w_pc3", pc2, 32'h4);
        chk("w_ipc3", ipc2, 32'h0);
        chk("w_out3", out2, 32'h0);
        chk("w_count3", 32'(count2), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
